// File: rtl/vTPU_pkg_fp6.sv
// Shared types and helpers for the FP6 VEGETA accumulator drain stage.
// Lane narrowing saturates when VEGETA_ACC_DRAIN_SAT_EN is defined, else wraps.
package vTPU_pkg_fp6;

    localparam int ACC_ALPHA            = 2;
    localparam int ACC_BETA             = 2;
    localparam int LANES                = ACC_ALPHA * ACC_BETA;
    localparam int ACC_ADD_DW           = 16;
    localparam int OUT_DATAWIDTH        = 8;
    localparam int ACC_DRAIN_FIFO_DEPTH = 8;

    typedef struct packed {
        logic [LANES-1:0][OUT_DATAWIDTH-1:0] data;
        logic [7:0]                          scale;
    } acc_drain_entry_t;

`ifdef VEGETA_ACC_DRAIN_SAT_EN
    localparam logic signed [ACC_ADD_DW-1:0] ACC_SAT_HI =
        ACC_ADD_DW'((1 << (OUT_DATAWIDTH-1)) - 1);
    localparam logic signed [ACC_ADD_DW-1:0] ACC_SAT_LO =
        ACC_ADD_DW'(-(1 << (OUT_DATAWIDTH-1)));
`endif

    function automatic logic [OUT_DATAWIDTH-1:0] acc_narrow(
        input logic signed [ACC_ADD_DW-1:0] v
    );
`ifdef VEGETA_ACC_DRAIN_SAT_EN
        if (v > ACC_SAT_HI)
            return OUT_DATAWIDTH'(ACC_SAT_HI);
        if (v < ACC_SAT_LO)
            return OUT_DATAWIDTH'(ACC_SAT_LO);
`endif
        return OUT_DATAWIDTH'(v);
    endfunction

endpackage

// File: rtl/vegeta_drain_fifo.sv
// Synchronous FIFO with occupancy count; output word is gated to zero when empty.
// A push into a full FIFO only lands if a pop frees a slot in the same cycle.
module vegeta_drain_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    // Pointer and count bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vegeta_acc_drain_fp6.sv
// Drain below the FP6 VEGETA PE array: deskew, narrow, buffer, hand off.
// Optional lane saturation: VEGETA_ACC_DRAIN_SAT_EN (default build wraps).
module vegeta_acc_drain_fp6 #(
    parameter int ALPHA         = 2,
    parameter int BETA          = 2,
    parameter int ADD_DATAWIDTH = 16,
    parameter int OUT_DATAWIDTH = 8,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ALPHA*BETA*ADD_DATAWIDTH-1:0]    acc_in,
    input  logic                                   acc_valid_in,
    input  logic [7:0]                             input_acc_scale,
    output logic                                   acc_stall,
    output logic [ALPHA*BETA*OUT_DATAWIDTH-1:0]    out_data,
    output logic [7:0]                             out_scale,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   overflow_err
);

    import vTPU_pkg_fp6::*;

    localparam int NL = ALPHA * BETA;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(NL) + 1;

    logic [NL-1:0][ADD_DATAWIDTH-1:0] lane_al;
    logic [NL-2:0]                    vpipe;
    logic [NL-2:0][7:0]               spipe;
    logic [IW-1:0]                    inflight;
    logic [CW:0]                      occ;
    logic [CW-1:0]                    fifo_count;
    logic                             fifo_full;
    logic                             wr_push;
    logic                             pop;
    acc_drain_entry_t                 wr_entry;
    acc_drain_entry_t                 rd_entry;

    for (genvar i = 0; i < NL; i++) begin : g_skew
        localparam int D = NL - 1 - i;
        if (D == 0) begin : g_pass
            assign lane_al[i] = acc_in[i*ADD_DATAWIDTH +: ADD_DATAWIDTH];
        end else begin : g_dly
            logic [D-1:0][ADD_DATAWIDTH-1:0] sr;
            // Delay early lanes so every lane lines up with the last one.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr[0] <= acc_in[i*ADD_DATAWIDTH +: ADD_DATAWIDTH];
                    for (int k = 1; k < D; k++)
                        sr[k] <= sr[k-1];
                end
            end
            assign lane_al[i] = sr[D-1];
        end
    end

    // Valid bit and scale ride alongside lane 0 through the skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            spipe <= '0;
        end else begin
            vpipe[0] <= acc_valid_in;
            spipe[0] <= input_acc_scale;
            for (int k = 1; k < NL - 1; k++) begin
                vpipe[k] <= vpipe[k-1];
                spipe[k] <= spipe[k-1];
            end
        end
    end

    // Build the narrowed FIFO entry from the aligned lanes.
    always_comb begin
        wr_entry       = '0;
        wr_entry.scale = spipe[NL-2];
        for (int i = 0; i < NL; i++)
            wr_entry.data[i] = acc_narrow(lane_al[i]);
    end

    // Stall once buffered plus in-flight vectors would fill the FIFO.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < NL - 1; k++)
            inflight = inflight + IW'(vpipe[k]);
        occ       = {1'b0, fifo_count} + (CW+1)'(inflight);
        acc_stall = (occ >= (CW+1)'(FIFO_DEPTH));
    end

    assign wr_push = vpipe[NL-2];
    assign pop     = out_valid && out_ready;

    vegeta_drain_fifo #(
        .WIDTH ($bits(acc_drain_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (rd_entry),
        .valid (out_valid),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign out_data  = rd_entry.data;
    assign out_scale = rd_entry.scale;

    // Sticky flag for a vector dropped against a full, non-draining FIFO.
    always_ff @(posedge clk) begin
        if (rst)
            overflow_err <= 1'b0;
        else if (wr_push && fifo_full && !pop)
            overflow_err <= 1'b1;
    end

endmodule

// File: tb/tb_vegeta_acc_drain_fp6.sv
// Directed bench for vegeta_acc_drain_fp6 (default parameters, 4 lanes).
// Expected lane values follow VEGETA_ACC_DRAIN_SAT_EN when it is defined.
module tb_vegeta_acc_drain_fp6;

    localparam int NL  = 4;
    localparam int ADW = 16;
    localparam int ODW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NL*ADW-1:0] acc_in;
    logic              acc_valid_in;
    logic [7:0]        input_acc_scale;
    logic              acc_stall;
    logic [NL*ODW-1:0] out_data;
    logic [7:0]        out_scale;
    logic              out_valid;
    logic              out_ready;
    logic              overflow_err;

    int checks   = 0;
    int failures = 0;

    logic signed [ADW-1:0] tab [16][NL];
    logic [7:0]            stab [16];

    int fs;
    bit sv;

    always #5 clk = ~clk;

    vegeta_acc_drain_fp6 dut (
        .clk             (clk),
        .rst             (rst),
        .acc_in          (acc_in),
        .acc_valid_in    (acc_valid_in),
        .input_acc_scale (input_acc_scale),
        .acc_stall       (acc_stall),
        .out_data        (out_data),
        .out_scale       (out_scale),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .overflow_err    (overflow_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int t);
        logic [31:0]           r;
        logic signed [ADW-1:0] v;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            v = tab[t][i];
            r[i*ODW +: ODW] = v[ODW-1:0];
        end
        return r;
    endfunction

    task automatic fill(input int t0, input int n, input int kb);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NL; i++)
                tab[t0+k][i] = 16'((10 * (kb + k) + i) % 100);
            stab[t0+k] = 8'(kb + k + 16);
        end
    endtask

    task automatic send(input int t0, input int n, input int rdy_at,
                        input int rst_at, output int first_stall,
                        output bit seen_valid);
        first_stall = -1;
        seen_valid  = 1'b0;
        for (int c = 0; c < n + NL - 1; c++) begin
            if (c == rst_at) begin
                rst          = 1'b1;
                acc_in       = '0;
                acc_valid_in = 1'b0;
                tick();
                rst = 1'b0;
                return;
            end
            for (int i = 0; i < NL; i++) begin
                int k;
                k = c - i;
                if (k >= 0 && k < n)
                    acc_in[i*ADW +: ADW] = tab[t0+k][i];
                else
                    acc_in[i*ADW +: ADW] = '0;
            end
            acc_valid_in = (c < n);
            if (c < n)
                input_acc_scale = stab[t0+c];
            else
                input_acc_scale = 8'h00;
            if (rdy_at >= 0)
                out_ready = (c == rdy_at);
            if (acc_stall && first_stall < 0)
                first_stall = c;
            if (out_valid)
                seen_valid = 1'b1;
            tick();
        end
        acc_in          = '0;
        acc_valid_in    = 1'b0;
        input_acc_scale = 8'h00;
        if (rdy_at >= 0)
            out_ready = 1'b0;
    endtask

    task automatic drain(input int t0, input int n, input string tag);
        out_ready = 1'b1;
        for (int j = 0; j < n; j++) begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"}, out_data, exp_data(t0 + j));
            chk({tag, "_scale"}, 32'(out_scale), 32'(stab[t0+j]));
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        acc_in          = '0;
        acc_valid_in    = 1'b0;
        input_acc_scale = 8'h00;
        out_ready       = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_scale", 32'(out_scale), 32'd0);
        chk("rst_stall", 32'(acc_stall), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        rst = 1'b0;
        tick();

        // Single vector: lanes {0,1,2,3}, scale 0x7F, valid 4 cycles later.
        fill(0, 1, 0);
        stab[0] = 8'h7F;
        send(0, 1, -1, -1, fs, sv);
        chk("t1_early_valid", 32'(sv), 32'd0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", out_data, 32'h03020100);
        chk("t1_scale", 32'(out_scale), 32'h7F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_empty", 32'(out_valid), 32'd0);

        // Eight back-to-back vectors into a blocked consumer.
        fill(0, 8, 0);
        send(0, 8, -1, -1, fs, sv);
        chk("t2_first_stall", 32'(fs), 32'd8);
        chk("t2_stall", 32'(acc_stall), 32'd1);
        chk("t2_ovf", 32'(overflow_err), 32'd0);
        chk("t2_hold0", out_data, exp_data(0));
        tick();
        tick();
        chk("t2_hold1", out_data, exp_data(0));
        chk("t2_hold_scale", 32'(out_scale), 32'(stab[0]));
        drain(0, 8, "t2");
        chk("t2_empty", 32'(out_valid), 32'd0);
        chk("t2_unstall", 32'(acc_stall), 32'd0);

        // Forced write into a full FIFO is dropped and flagged.
        send(0, 8, -1, -1, fs, sv);
        fill(8, 1, 50);
        send(8, 1, -1, -1, fs, sv);
        chk("t3_ovf", 32'(overflow_err), 32'd1);
        drain(0, 8, "t3");
        chk("t3_empty", 32'(out_valid), 32'd0);
        chk("t3_ovf_sticky", 32'(overflow_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t3_ovf_clear", 32'(overflow_err), 32'd0);
        tick();

        // Narrowing boundaries.
        tab[0][0] = 16'sd300;
        tab[0][1] = -16'sd200;
        tab[0][2] = 16'sd127;
        tab[0][3] = -16'sd129;
        stab[0]   = 8'hA5;
        send(0, 1, -1, -1, fs, sv);
`ifdef VEGETA_ACC_DRAIN_SAT_EN
        chk("t4_narrow", out_data, 32'h807F807F);
`else
        chk("t4_narrow", out_data, 32'h7F7F382C);
`endif
        chk("t4_scale", 32'(out_scale), 32'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Full FIFO with a pop and a write in the same cycle, across wrap.
        fill(0, 9, 20);
        send(0, 8, -1, -1, fs, sv);
        send(8, 1, 3, -1, fs, sv);
        chk("t5_stall", 32'(acc_stall), 32'd1);
        chk("t5_ovf", 32'(overflow_err), 32'd0);
        drain(1, 8, "t5");
        chk("t5_empty", 32'(out_valid), 32'd0);

        // Reset with 3 vectors buffered and 2 in flight.
        fill(0, 5, 40);
        send(0, 5, -1, 6, fs, sv);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_stall", 32'(acc_stall), 32'd0);
        repeat (6) tick();
        chk("t6_quiet", 32'(out_valid), 32'd0);
        fill(0, 1, 60);
        send(0, 1, -1, -1, fs, sv);
        chk("t6_new_valid", 32'(out_valid), 32'd1);
        chk("t6_new_data", out_data, exp_data(0));
        chk("t6_new_scale", 32'(out_scale), 32'(stab[0]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_alone", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vegeta_acc_drain_fp6.md
# vegeta_acc_drain_fp6

Output drain stage that sits directly below the bottom row of the FP6 VEGETA PE array and consumes the `acc_out` partial-sum bus together with its shared 8-bit scale. Systolic skew leaves lane i one cycle behind lane i-1. The block deskews the lanes into aligned output vectors, narrows each lane to the output width, and buffers the vectors in a FIFO. It hands them to the writeback path over a valid/ready handshake, and raises a stall toward the array controller so the FIFO never overflows.

## Interface
Parameters:
- `ALPHA`, 2: PUs per PE; lanes = `ALPHA*BETA`.
- `BETA`, 2: accumulators per PU.
- `ADD_DATAWIDTH`, 16: signed accumulator lane width.
- `OUT_DATAWIDTH`, 8: signed output lane width; must be ≤ `ADD_DATAWIDTH`.
- `FIFO_DEPTH`, 8: output vector entries; power of two, ≥ 2.

Ports:
- Clocking and reset (decided): one clock; reset is synchronous and active-high. `clk` is the clock and `rst` is the reset.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `acc_in`  in  `ALPHA*BETA*ADD_DATAWIDTH`  skewed partial sums; lane i at bits `[i*ADD_DATAWIDTH +: ADD_DATAWIDTH]`.
- `acc_valid_in`  in  1  marks lane 0 of a new vector this cycle.
- `input_acc_scale`  in  8  shared scale, sampled with lane 0.
- `acc_stall`  out  1  upstream must not assert `acc_valid_in` while high.
- `out_data`  out  `ALPHA*BETA*OUT_DATAWIDTH`  aligned output vector.
- `out_scale`  out  8  scale of `out_data`.
- `out_valid`  out  1  vector available.
- `out_ready`  in  1  consumer accepts.
- `overflow_err`  out  1  sticky; a write was attempted while the FIFO was full.

## Operation
- Deskew: lane i is delayed by `LANES-1-i` register stages, where `LANES = ALPHA*BETA`. Lane `LANES-1` passes with zero extra delay.
- `acc_valid_in` and `input_acc_scale` travel down a `LANES-1`-stage pipe alongside lane 0.
- When the valid bit reaches the end of its pipe, the aligned vector is written into the FIFO.
- Lane narrowing (see Configuration) is applied on FIFO write. The FIFO stores `LANES*OUT_DATAWIDTH + 8` bits per entry.
- Handshake: a pop happens in the cycle where `out_valid && out_ready`.
  - `out_data` and `out_scale` hold stable while `out_valid=1 && !out_ready`.
- `inflight` is the number of set bits in the valid pipe. `acc_stall = (fifo_count + inflight) >= FIFO_DEPTH`. It is combinational from registers only, with no dependency on `acc_valid_in`.
- Full FIFO with a write and a pop in the same cycle: both occur, the count is unchanged, and `overflow_err` is not set.
- Full FIFO with a write and no pop: the write is dropped and `overflow_err` sets. It stays set until `rst`.
- Empty FIFO with a write in the same cycle: there is no bypass. `out_valid` rises the next cycle.
- Read and write pointers wrap modulo `FIFO_DEPTH`. A count register of `$clog2(FIFO_DEPTH)+1` bits distinguishes full from empty.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_scale=0`, `acc_stall=0`, `overflow_err=0`.
  - The valid pipe and skew registers are cleared, the FIFO is empty, and the pointers are 0.
- Latency: with `acc_valid_in` at cycle t and the FIFO empty, the FIFO write happens at the end of cycle t+`LANES-1` and `out_valid=1` in cycle t+`LANES`.
- Throughput: one vector per cycle while `out_ready=1`.
- Reset mid-operation: all in-flight and buffered vectors are discarded. No partial vector ever emerges after reset.
- `acc_stall` reflects state at the start of the cycle. Upstream samples it in the same cycle it would issue.

## Configuration
- Macro: `VEGETA_ACC_DRAIN_SAT_EN`.
- When defined, each lane saturates to the signed `OUT_DATAWIDTH` range [-2^(OUT-1), 2^(OUT-1)-1].
- When undefined, each lane truncates to its low `OUT_DATAWIDTH` bits (two's-complement wrap).

## Structure
- The shared package `vTPU_pkg_fp6` holds:
  - `LANES`, `OUT_DATAWIDTH`, `ACC_DRAIN_FIFO_DEPTH`;
  - the FIFO entry struct `acc_drain_entry_t` (`data`, `scale`);
  - the narrowing function `acc_narrow()`.
- The block has one sub-module, `vegeta_drain_fifo`: a parameterized synchronous FIFO with count, full, empty, and registered output.
- The deskew triangle and the stall logic stay in the top module.

## Test plan
- Defaults: lanes=4. Vector k has lane i value 10k+i, with lane i driven at cycles 5+i and `acc_valid_in` at cycle 5 → `out_valid` at cycle 9, `out_data` lanes = {0,1,2,3}, `out_scale` = sampled scale 0x7F.
- 8 back-to-back vectors with `out_ready=0` → `acc_stall` rises once count+inflight reaches 8. No write is lost, `overflow_err=0`, and all 8 vectors drain in order after `out_ready=1`.
- Force `acc_valid_in` while `acc_stall=1` with the FIFO full and `out_ready=0` → `overflow_err=1` and stays 1. The FIFO contents are unchanged.
- Lane values 300 and -200:
  - with `VEGETA_ACC_DRAIN_SAT_EN` → outputs 127 and -128;
  - without → 44 (0x2C) and 56 (0x38).
- Full FIFO with `out_ready=1` and a write arriving in the same cycle → count stays 8 and `overflow_err=0`. Order is preserved across pointer wrap.
- Assert `rst` with 3 vectors buffered and 2 in flight → the next cycle shows `out_valid=0` and `acc_stall=0`. After release, a new vector emerges alone with correct data.
